hermes_packet_injector: RTL and testbench

// Packetizer feeding a HermesRouter input port (normally LOCAL) from a processing element.

---
 rtl/hermes_packet_injector_pkg.sv | 15 +
 rtl/hermes_packet_injector_if.sv | 37 +++
 rtl/hermes_flit_reg.sv | 50 +++++
 rtl/hermes_packet_injector.sv | 161 ++++++++++++++++
 tb/tb_hermes_packet_injector.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hermes_packet_injector_pkg.sv
// Shared types and constants for the Hermes packet injector.
//   HERMES_ADDR_W      : width of the router address carried in the header flit
//   hermes_inj_state_t : injector FSM state encoding
package hermes_packet_injector_pkg;

  localparam int unsigned HERMES_ADDR_W = 16;

  typedef enum logic [1:0] {
    INJ_IDLE,
    INJ_HEADER,
    INJ_SIZE,
    INJ_PAYLOAD
  } hermes_inj_state_t;

endpackage

// File: rtl/hermes_packet_injector_if.sv
// Interface bundling the injector's descriptor, payload and router-link signals.
//   req_*      : packet descriptor handshake (target, payload length)
//   pl_*       : payload word handshake
//   tx/eop/data: flit link toward router rx_i/data_i, credit_i is the router credit
//   busy/done  : packet status
// Modport slave is the injector side, master is the PE/router side.
interface hermes_packet_injector_if #(
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned LEN_W     = 16
);
  import hermes_packet_injector_pkg::*;

  logic                     req_valid_i;
  logic                     req_ready_o;
  logic [HERMES_ADDR_W-1:0] req_target_i;
  logic [LEN_W-1:0]         req_len_i;
  logic                     pl_valid_i;
  logic                     pl_ready_o;
  logic [FLIT_SIZE-1:0]     pl_data_i;
  logic                     tx_o;
  logic                     eop_o;
  logic [FLIT_SIZE-1:0]     data_o;
  logic                     credit_i;
  logic                     busy_o;
  logic                     done_o;

  modport slave (
    input  req_valid_i, req_target_i, req_len_i, pl_valid_i, pl_data_i, credit_i,
    output req_ready_o, pl_ready_o, tx_o, eop_o, data_o, busy_o, done_o
  );

  modport master (
    output req_valid_i, req_target_i, req_len_i, pl_valid_i, pl_data_i, credit_i,
    input  req_ready_o, pl_ready_o, tx_o, eop_o, data_o, busy_o, done_o
  );

endinterface

// File: rtl/hermes_flit_reg.sv
// One-entry registered flit output stage with credit-based drain.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_load       : load i_data/i_eop (honoured only while o_free)
//   i_credit     : downstream credit; a flit transfers on o_tx && i_credit
//   o_tx/o_eop/o_data : registered flit toward the router
//   o_free       : entry empty or draining this cycle
module hermes_flit_reg #(
  parameter int unsigned FLIT_SIZE = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_load,
  input  logic [FLIT_SIZE-1:0] i_data,
  input  logic                 i_eop,
  input  logic                 i_credit,
  output logic                 o_tx,
  output logic                 o_eop,
  output logic [FLIT_SIZE-1:0] o_data,
  output logic                 o_free
);

  logic                 r_tx;
  logic                 r_eop;
  logic [FLIT_SIZE-1:0] r_data;
  logic                 w_free;

  assign w_free = !r_tx || i_credit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tx   <= 1'b0;
      r_eop  <= 1'b0;
      r_data <= '0;
    end else if (i_load && w_free) begin
      r_tx   <= 1'b1;
      r_eop  <= i_eop;
      r_data <= i_data;
    end else if (w_free) begin
      // Drained with nothing new: eop is only meaningful alongside tx.
      r_tx  <= 1'b0;
      r_eop <= 1'b0;
    end
  end

  assign o_tx   = r_tx;
  assign o_eop  = r_eop;
  assign o_data = r_data;
  assign o_free = w_free;

endmodule

// File: rtl/hermes_packet_injector.sv
// Hermes packetizer: turns a descriptor (target, len) plus a payload stream into
// header, size and payload flits on a credit-controlled router input link.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   inj          : descriptor/payload/link/status signals (slave modport)
module hermes_packet_injector
  import hermes_packet_injector_pkg::*;
#(
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned LEN_W     = 16
) (
  input logic                     clk_i,
  input logic                     rst_i,
  hermes_packet_injector_if.slave inj
);

  hermes_inj_state_t        r_state;
  hermes_inj_state_t        w_state_next;
  logic [HERMES_ADDR_W-1:0] r_target;
  logic [LEN_W-1:0]         r_len;
  logic [LEN_W-1:0]         r_cnt;
  logic                     r_done;

  logic                 w_free;
  logic                 w_load;
  logic [FLIT_SIZE-1:0] w_load_data;
  logic                 w_load_eop;
  logic                 w_req_ready;
  logic                 w_pl_ready;
  logic                 w_pl_hs;
  logic                 w_last;
  logic                 w_tx;
  logic                 w_eop;
  logic [FLIT_SIZE-1:0] w_data;

  assign w_pl_hs = inj.pl_valid_i && w_pl_ready;
  assign w_last  = (r_cnt == LEN_W'(1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= INJ_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. An accepted descriptor loads its header straight from the
  // request when the output entry is free, so a new packet follows a draining
  // eop flit without a bubble; HEADER is only used when that load must wait.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      INJ_IDLE: begin
        if (inj.req_valid_i) begin
          w_state_next = w_free ? INJ_SIZE : INJ_HEADER;
        end
      end
      INJ_HEADER: begin
        if (w_free) begin
          w_state_next = INJ_SIZE;
        end
      end
      INJ_SIZE: begin
        if (w_free) begin
          w_state_next = (r_len == '0) ? INJ_IDLE : INJ_PAYLOAD;
        end
      end
      INJ_PAYLOAD: begin
        if (w_pl_hs && w_last) begin
          w_state_next = INJ_IDLE;
        end
      end
      default: w_state_next = INJ_IDLE;
    endcase
  end

  // Output / load-control logic
  always_comb begin
    w_req_ready = 1'b0;
    w_pl_ready  = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_eop  = 1'b0;
    unique case (r_state)
      INJ_IDLE: begin
        w_req_ready = 1'b1;
        if (inj.req_valid_i && w_free) begin
          w_load      = 1'b1;
          w_load_data = FLIT_SIZE'(inj.req_target_i);
        end
      end
      INJ_HEADER: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_data = FLIT_SIZE'(r_target);
        end
      end
      INJ_SIZE: begin
        if (w_free) begin
          w_load      = 1'b1;
          w_load_data = FLIT_SIZE'(r_len);
          w_load_eop  = (r_len == '0);
        end
      end
      INJ_PAYLOAD: begin
        w_pl_ready = w_free;
        if (w_pl_hs) begin
          w_load      = 1'b1;
          w_load_data = inj.pl_data_i;
          w_load_eop  = w_last;
        end
      end
      default: ;
    endcase
  end

  // Descriptor latches, payload counter and done pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_target <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_tx && inj.credit_i && w_eop;
      if (r_state == INJ_IDLE && inj.req_valid_i) begin
        r_target <= inj.req_target_i;
        r_len    <= inj.req_len_i;
      end
      if (r_state == INJ_SIZE && w_free) begin
        r_cnt <= r_len;
      end else if (w_pl_hs) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  hermes_flit_reg #(
    .FLIT_SIZE (FLIT_SIZE)
  ) u_flit_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_load),
    .i_data   (w_load_data),
    .i_eop    (w_load_eop),
    .i_credit (inj.credit_i),
    .o_tx     (w_tx),
    .o_eop    (w_eop),
    .o_data   (w_data),
    .o_free   (w_free)
  );

  assign inj.req_ready_o = w_req_ready;
  assign inj.pl_ready_o  = w_pl_ready;
  assign inj.tx_o        = w_tx;
  assign inj.eop_o       = w_eop;
  assign inj.data_o      = w_data;
  assign inj.busy_o      = (r_state != INJ_IDLE) || w_tx;
  assign inj.done_o      = r_done;

endmodule

// File: tb/tb_hermes_packet_injector.sv
`timescale 1ns/1ps
module tb_hermes_packet_injector;
  import hermes_packet_injector_pkg::*;

  localparam int unsigned FLIT_SIZE = 32;
  localparam int unsigned LEN_W     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hermes_packet_injector_if #(.FLIT_SIZE(FLIT_SIZE), .LEN_W(LEN_W)) u_if ();

  hermes_packet_injector #(
    .FLIT_SIZE (FLIT_SIZE),
    .LEN_W     (LEN_W)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .inj   (u_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each packet is the flit list {header, size, payload...},
  // eop set on the last one. Entries are {eop, data}.
  logic [FLIT_SIZE:0]   exp_q[$];
  logic [FLIT_SIZE-1:0] pl_q[$];

  int pl_mode  = 0;  // 0 always valid, 1 toggling, 2 random
  int cr_mode  = 0;  // 0 always 1, 2 one 3-cycle stall at stall_at, 3 random
  int stall_at = -1;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: transfers, stall stability, done pulse
  int                 n_xfer     = 0;
  int                 pl_rdy_cnt = 0;
  int                 xfer_cyc[int];
  logic [FLIT_SIZE:0] xfer_rec[int];
  logic               prev_tx = 1'b0, prev_credit = 1'b0, prev_eop_xfer = 1'b0;
  logic [FLIT_SIZE+1:0] prev_flit = '0;

  always @(negedge clk) begin : monitor
    logic [FLIT_SIZE:0] got;
    logic [FLIT_SIZE:0] e;
    if (rst) begin
      prev_tx       = 1'b0;
      prev_eop_xfer = 1'b0;
    end else begin
      chk("done_o", u_if.done_o, prev_eop_xfer);
      if (prev_tx && !prev_credit)
        chk("stall_hold", {u_if.tx_o, u_if.eop_o, u_if.data_o}, prev_flit);
      if (u_if.pl_ready_o) pl_rdy_cnt++;
      if (u_if.tx_o && u_if.credit_i) begin
        got = {u_if.eop_o, u_if.data_o};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_flit: got 0x%0h, expected no flit", got);
        end else begin
          e = exp_q.pop_front();
          chk("flit", got, e);
        end
        xfer_cyc[n_xfer] = cyc;
        xfer_rec[n_xfer] = got;
        n_xfer++;
      end
      prev_eop_xfer = u_if.tx_o && u_if.credit_i && u_if.eop_o;
      prev_tx       = u_if.tx_o;
      prev_credit   = u_if.credit_i;
      prev_flit     = {u_if.tx_o, u_if.eop_o, u_if.data_o};
    end
  end

  // Payload source: presents pl_q head; garbage data while not valid
  initial begin : pl_drv
    logic                 phase;
    logic                 give;
    logic [FLIT_SIZE-1:0] tmp;
    phase = 1'b0;
    u_if.pl_valid_i = 1'b0;
    u_if.pl_data_i  = '0;
    forever begin
      @(negedge clk);
      if (!rst && u_if.pl_valid_i && u_if.pl_ready_o && pl_q.size() > 0) tmp = pl_q.pop_front();
      @(posedge clk);
      #1;
      phase = !phase;
      give  = (pl_mode == 0) || (pl_mode == 1 && phase) ||
              (pl_mode == 2 && $urandom_range(0, 1) == 1);
      if (pl_q.size() > 0 && give) begin
        u_if.pl_valid_i = 1'b1;
        u_if.pl_data_i  = pl_q[0];
      end else begin
        u_if.pl_valid_i = 1'b0;
        u_if.pl_data_i  = $urandom;
      end
    end
  end

  // Credit source
  initial begin : cr_drv
    int stalled;
    int last_x;
    stalled = 0;
    last_x  = -1;
    u_if.credit_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (n_xfer != last_x) stalled = 0;
      last_x = n_xfer;
      if (cr_mode == 3) begin
        u_if.credit_i = ($urandom_range(0, 3) != 0);
      end else if (cr_mode == 2 && n_xfer == stall_at && stalled < 3) begin
        u_if.credit_i = 1'b0;
        stalled++;
      end else begin
        u_if.credit_i = 1'b1;
      end
    end
  end

  function automatic logic [FLIT_SIZE:0] rec(input int idx);
    return xfer_rec.exists(idx) ? xfer_rec[idx] : 'x;
  endfunction

  function automatic int rcyc(input int idx);
    return xfer_cyc.exists(idx) ? xfer_cyc[idx] : -1000;
  endfunction

  // Queues the expected packet and payload words, then performs the descriptor
  // handshake. Called and returns at posedge+1.
  task automatic send_desc(input logic [15:0] tgt, input logic [LEN_W-1:0] len,
                           output int hs_cyc);
    logic [FLIT_SIZE-1:0] w;
    bit got;
    got    = 1'b0;
    hs_cyc = -1;
    exp_q.push_back({1'b0, FLIT_SIZE'(tgt)});
    exp_q.push_back({(len == '0), FLIT_SIZE'(len)});
    for (int i = 0; i < int'(len); i++) begin
      w = $urandom;
      pl_q.push_back(w);
      exp_q.push_back({(i == int'(len) - 1), w});
    end
    u_if.req_valid_i  = 1'b1;
    u_if.req_target_i = tgt;
    u_if.req_len_i    = len;
    for (int k = 0; k < 500 && !got; k++) begin
      @(negedge clk);
      if (u_if.req_ready_o) begin
        got    = 1'b1;
        hs_cyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    u_if.req_valid_i  = 1'b0;
    u_if.req_target_i = $urandom;
    u_if.req_len_i    = $urandom;
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL req_timeout: req_ready_o=0 for 500 cycles, expected handshake");
    end
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d flits outstanding, expected 0", exp_q.size());
      exp_q.delete();
      pl_q.delete();
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [15:0]      target;
    logic [LEN_W-1:0] len;
    int               pl_mode;
    int               cr_mode;
    int               exp_flits;
    logic [31:0]      exp_hdr;
    logic [31:0]      exp_size;
    int               exp_span;  // last-first flit cycle; -1 means bubbles required
  } vec_t;

  vec_t vecs[4];

  initial begin : main
    int hs, hs2, base, rbase, span, guard;
    vecs[0] = '{16'h0102, 16'd3, 0, 0, 5, 32'h0000_0102, 32'h3, 4};
    vecs[1] = '{16'h0201, 16'd0, 0, 0, 2, 32'h0000_0201, 32'h0, 1};
    vecs[2] = '{16'h0304, 16'd4, 0, 2, 6, 32'h0000_0304, 32'h4, 8};
    vecs[3] = '{16'h0405, 16'd3, 1, 0, 5, 32'h0000_0405, 32'h3, -1};

    u_if.req_valid_i  = 1'b0;
    u_if.req_target_i = '0;
    u_if.req_len_i    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", u_if.tx_o, 0);
    chk("rst_eop", u_if.eop_o, 0);
    chk("rst_data", u_if.data_o, 0);
    chk("rst_done", u_if.done_o, 0);
    chk("rst_busy", u_if.busy_o, 0);
    chk("rst_pl_ready", u_if.pl_ready_o, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_req_ready", u_if.req_ready_o, 1);

    // Directed table
    foreach (vecs[v]) begin
      pl_mode  = vecs[v].pl_mode;
      cr_mode  = vecs[v].cr_mode;
      base     = n_xfer;
      stall_at = base + 1;
      rbase    = pl_rdy_cnt;
      send_desc(vecs[v].target, vecs[v].len, hs);
      wait_drain(300);
      chk($sformatf("v%0d_nflits", v), n_xfer - base, vecs[v].exp_flits);
      chk($sformatf("v%0d_hdr", v), rec(base), {1'b0, vecs[v].exp_hdr});
      chk($sformatf("v%0d_size", v), rec(base + 1), {(vecs[v].len == '0), vecs[v].exp_size});
      chk($sformatf("v%0d_latency", v), rcyc(base) - hs, 1);
      span = rcyc(n_xfer - 1) - rcyc(base);
      if (vecs[v].exp_span >= 0) chk($sformatf("v%0d_span", v), span, vecs[v].exp_span);
      else chk($sformatf("v%0d_bubbles", v), span > vecs[v].exp_flits - 1, 1);
      if (vecs[v].len == '0) chk("len0_pl_ready", pl_rdy_cnt - rbase, 0);
    end

    // Back-to-back len=1 then len=2: 7 flits on consecutive cycles
    pl_mode = 0;
    cr_mode = 0;
    base    = n_xfer;
    send_desc(16'h0506, 16'd1, hs);
    send_desc(16'h0607, 16'd2, hs2);
    wait_drain(300);
    chk("b2b_nflits", n_xfer - base, 7);
    chk("b2b_span", rcyc(base + 6) - rcyc(base), 6);
    chk("b2b_eop3", rec(base + 2) >> FLIT_SIZE, 1);
    chk("b2b_eop7", rec(base + 6) >> FLIT_SIZE, 1);
    chk("b2b_hdr2", rec(base + 3), {1'b0, 32'h0000_0607});

    // Maximum length, then reset in the middle of the payload
    base = n_xfer;
    send_desc(16'h0708, 16'hFFFF, hs);
    guard = 0;
    while (n_xfer < base + 4 && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("max_size_flit", rec(base + 1), {1'b0, 32'h0000_FFFF});
    chk("pre_rst_tx", u_if.tx_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx", u_if.tx_o, 0);
    chk("async_rst_eop", u_if.eop_o, 0);
    chk("async_rst_data", u_if.data_o, 0);
    chk("async_rst_done", u_if.done_o, 0);
    chk("async_rst_busy", u_if.busy_o, 0);
    exp_q.delete();
    pl_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_req_ready", u_if.req_ready_o, 1);
    base = n_xfer;
    send_desc(16'h0809, 16'd2, hs);
    wait_drain(300);
    chk("post_rst_nflits", n_xfer - base, 4);
    chk("post_rst_hdr", rec(base), {1'b0, 32'h0000_0809});

    // Randomized traffic against the flit-list model
    pl_mode = 2;
    cr_mode = 3;
    for (int p = 0; p < 30; p++) begin
      send_desc(16'($urandom), LEN_W'($urandom_range(0, 6)), hs);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain(3000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
